// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and helpers for the iterative RV32M mul/div unit:
//               funct3 operation encodings, FSM state encodings and operand
//               classification functions.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // funct3 encodings of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Divide family (quotient or remainder)
  function automatic logic is_div(input logic [2:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Remainder ops return the remainder word instead of the quotient
  function automatic logic is_rem(input logic [2:0] op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // rs1 is interpreted as two's complement
  function automatic logic is_signed_a(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic is_signed_b(input logic [2:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : E-stage issue / result bundle between the pipeline (master)
//               and the iterative mul/div unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_start;
  logic [2:0]            i_op;
  logic [DATA_WIDTH-1:0] i_rs1;
  logic [DATA_WIDTH-1:0] i_rs2;
  logic [4:0]            i_rd_in;
  logic                  i_flush;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_result;
  logic [4:0]            o_rd_out;

  modport master (
    output i_start, i_op, i_rs1, i_rs2, i_rd_in, i_flush,
    input  o_busy, o_done, o_result, o_rd_out
  );

  modport slave (
    input  i_start, i_op, i_rs1, i_rs2, i_rd_in, i_flush,
    output o_busy, o_done, o_result, o_rd_out
  );
endinterface : muldiv_if
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide on operand magnitudes, one bit per cycle,
//               with the sign applied when the last iteration retires.
//               Divide-by-zero and signed overflow bypass the iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  muldiv_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int W     = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_CALC = 2'(ST_CALC);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);
  localparam logic [W-1:0]     MOST_NEG  = {1'b1, {(W-1){1'b0}}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_acc;     // {hi, lo}: mul {partial sum, multiplier}; div {remainder, quotient}
  logic [W-1:0]     r_src;     // multiplicand magnitude or divisor magnitude
  logic [2:0]       r_op;
  logic             r_neg;     // sign to apply to the selected result word
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_result;
  logic [4:0]       r_rd;

  // ---- accept-time operand preparation ----
  logic         w_accept;
  logic         w_sa;
  logic         w_sb;
  logic         w_neg;
  logic [W-1:0] w_mag_a;
  logic [W-1:0] w_mag_b;
  logic         w_div_zero;
  logic         w_ovf;
  logic         w_special;
  logic [W-1:0] w_special_res;

  assign w_accept   = (r_state == S_IDLE) && bus.i_start && !bus.i_flush;
  assign w_sa       = is_signed_a(bus.i_op) & bus.i_rs1[W-1];
  assign w_sb       = is_signed_b(bus.i_op) & bus.i_rs2[W-1];
  assign w_mag_a    = w_sa ? (-bus.i_rs1) : bus.i_rs1;
  assign w_mag_b    = w_sb ? (-bus.i_rs2) : bus.i_rs2;
  // Remainder takes the dividend's sign; product and quotient take the XOR
  assign w_neg      = is_rem(bus.i_op) ? w_sa : (w_sa ^ w_sb);
  assign w_div_zero = is_div(bus.i_op) && (bus.i_rs2 == '0);
  assign w_ovf      = (bus.i_op == OP_DIV || bus.i_op == OP_REM) &&
                      (bus.i_rs1 == MOST_NEG) && (bus.i_rs2 == '1);
  assign w_special  = w_div_zero || w_ovf;
  assign w_special_res = w_div_zero ? (is_rem(bus.i_op) ? bus.i_rs1 : '1)
                                    : (is_rem(bus.i_op) ? '0 : bus.i_rs1);

  // ---- one iteration of the datapath ----
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [W:0]     w_rem_sh;
  logic [W:0]     w_diff;
  logic           w_ge;
  logic [2*W-1:0] w_div_next;

  // Add multiplicand when the current multiplier bit is set, then shift right
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_src} : {(W+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Shift next dividend bit into the remainder and trial-subtract the divisor
  assign w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_src};
  assign w_ge       = ~w_diff[W];
  assign w_div_next = {(w_ge ? w_diff[W-1:0] : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge};

  // ---- final sign correction and word select ----
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_div_word;
  logic [W-1:0]   w_div_res;
  logic [W-1:0]   w_mul_res;
  logic [W-1:0]   w_final;

  assign w_prod     = r_neg ? (-w_mul_next) : w_mul_next;
  assign w_mul_res  = (r_op == OP_MUL) ? w_prod[W-1:0] : w_prod[2*W-1:W];
  assign w_div_word = is_rem(r_op) ? w_div_next[2*W-1:W] : w_div_next[W-1:0];
  assign w_div_res  = r_neg ? (-w_div_word) : w_div_word;
  assign w_final    = is_div(r_op) ? w_div_res : w_mul_res;

  // Controller and datapath registers; flush and reset both abort to IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_src    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (bus.i_flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd  <= bus.i_rd_in;
            r_op  <= bus.i_op;
            r_neg <= w_neg;
            r_cnt <= '0;
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= S_DONE;
              r_done   <= 1'b1;
            end else begin
              // Dividend (div) or multiplier (mul) sits in the low half
              r_acc   <= is_div(bus.i_op) ? {{W{1'b0}}, w_mag_a} : {{W{1'b0}}, w_mag_b};
              r_src   <= is_div(bus.i_op) ? w_mag_b : w_mag_a;
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_acc <= is_div(r_op) ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_result <= w_final;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_result = r_result;
  assign bus.o_rd_out = r_rd;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit with an arithmetic
//               reference model of the RV32M operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] last_exp;

  muldiv_if #(.DATA_WIDTH(32)) bus ();

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = 64'd0;
    case (op)
      3'b000: begin p = sa * sb; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Issue one operation and observe it until done (bounded); returns timing
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int done_cyc, output int busy_cnt,
                       output int busy_first, output int overlap,
                       output logic [31:0] res, output logic [4:0] rd_o);
    done_cyc = 0; busy_cnt = 0; busy_first = 0; overlap = 0; res = '0; rd_o = '0;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_op = op; bus.i_rs1 = a; bus.i_rs2 = b; bus.i_rd_in = rd;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.o_busy) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = c;
      end
      if (bus.o_busy && bus.o_done) overlap++;
      if (bus.o_done) begin
        done_cyc = c; res = bus.o_result; rd_o = bus.o_rd_out;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_busy, bus.o_done, bus.o_result, bus.o_rd_out} !== 39'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h rd=%0d, want all 0",
               bus.o_busy, bus.o_done, bus.o_result, bus.o_rd_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_mul();
    int d, bc, bf, ov;
    logic [31:0] r;
    logic [4:0] ro;
    logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 5'(i + 9), d, bc, bf, ov, r, ro);
      n_checks++;
      if (r !== ex[i]) begin
        n_errors++; $display("FAIL mul_result[%0d]: got %h, want %h", i, r, ex[i]);
      end
      n_checks++;
      if (d !== 33 || bc !== 32 || bf !== 1 || ov !== 0) begin
        n_errors++;
        $display("FAIL mul_timing[%0d]: got done_cyc=%0d busy_cnt=%0d busy_first=%0d overlap=%0d, want 33/32/1/0",
                 i, d, bc, bf, ov);
      end
      n_checks++;
      if (ro !== 5'(i + 9)) begin
        n_errors++; $display("FAIL mul_rd[%0d]: got %0d, want %0d", i, ro, i + 9);
      end
      last_exp = ex[i];
    end
  endtask

  task automatic test_back_to_back();
    int d, bc, bf, ov;
    logic [31:0] r;
    logic [4:0] ro;
    logic [2:0]  ops [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
    logic [31:0] ex  [4] = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], 32'd7, 5'(20 + i), d, bc, bf, ov, r, ro);
      n_checks++;
      if (r !== ex[i] || d !== 33 || bc !== 32) begin
        n_errors++;
        $display("FAIL div_b2b[%0d]: got result=%h done_cyc=%0d busy_cnt=%0d, want %h/33/32",
                 i, r, d, bc, ex[i]);
      end
      last_exp = ex[i];
    end
  endtask

  task automatic test_special();
    int d, bc, bf, ov;
    logic [31:0] r;
    logic [4:0] ro;
    issue(3'b100, 32'd5, 32'd0, 5'd3, d, bc, bf, ov, r, ro);
    n_checks++;
    if (r !== 32'hFFFF_FFFF || d !== 1 || bc !== 0) begin
      n_errors++;
      $display("FAIL div_by_zero: got result=%h done_cyc=%0d busy_cnt=%0d, want ffffffff/1/0", r, d, bc);
    end
    n_checks++;
    if (ro !== 5'd3) begin
      n_errors++; $display("FAIL div_by_zero_rd: got %0d, want 3", ro);
    end
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, d, bc, bf, ov, r, ro);
    n_checks++;
    if (r !== 32'd0 || d !== 1 || bc !== 0) begin
      n_errors++;
      $display("FAIL rem_overflow: got result=%h done_cyc=%0d busy_cnt=%0d, want 0/1/0", r, d, bc);
    end
    last_exp = 32'd0;
  endtask

  task automatic test_flush();
    int d, bc, bf, ov, done_seen;
    logic [31:0] r;
    logic [4:0] ro;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_op = 3'b101; bus.i_rs1 = 32'd1000; bus.i_rs2 = 32'd3; bus.i_rd_in = 5'd11;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      n_errors++; $display("FAIL flush_idle: got busy=%b done=%b, want 0/0", bus.o_busy, bus.o_done);
    end
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.o_done || bus.o_busy) done_seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (done_seen !== 0) begin
      n_errors++; $display("FAIL flush_no_done: got %0d active cycles, want 0", done_seen);
    end
    n_checks++;
    if (bus.o_result !== last_exp) begin
      n_errors++; $display("FAIL flush_result_kept: got %h, want %h", bus.o_result, last_exp);
    end
    issue(3'b000, 32'd3, 32'd4, 5'd12, d, bc, bf, ov, r, ro);
    n_checks++;
    if (r !== 32'd12 || d !== 33) begin
      n_errors++; $display("FAIL mul_after_flush: got result=%h done_cyc=%0d, want 0000000c/33", r, d);
    end
    last_exp = 32'd12;
    // start together with flush must not be accepted
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_flush = 1'b1; bus.i_op = 3'b000; bus.i_rs1 = 32'd5; bus.i_rs2 = 32'd5;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_flush = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.o_done || bus.o_busy) done_seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (done_seen !== 0 || bus.o_result !== last_exp) begin
      n_errors++;
      $display("FAIL start_with_flush: got %0d active cycles result=%h, want 0 and %h",
               done_seen, bus.o_result, last_exp);
    end
  endtask

  task automatic test_rst_mid();
    int d, bc, bf, ov;
    logic [31:0] r;
    logic [4:0] ro;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_op = 3'b000; bus.i_rs1 = 32'h1234; bus.i_rs2 = 32'h5678; bus.i_rd_in = 5'd7;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.o_busy, bus.o_done, bus.o_result, bus.o_rd_out} !== 39'd0) begin
      n_errors++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b result=%h rd=%0d, want all 0",
               bus.o_busy, bus.o_done, bus.o_result, bus.o_rd_out);
    end
    rst = 1'b1;
    issue(3'b101, 32'd9, 32'd3, 5'd2, d, bc, bf, ov, r, ro);
    n_checks++;
    if (r !== 32'd3 || d !== 33) begin
      n_errors++; $display("FAIL divu_after_rst: got result=%h done_cyc=%0d, want 3/33", r, d);
    end
    last_exp = 32'd3;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int d, bc, bf, ov, exp_cyc;
    logic [31:0] r, a, b, ex;
    logic [4:0] ro, rd;
    logic [2:0] op;
    logic special;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(0, 31));
      ex = ref_model(op, a, b);
      special = op[2] && (b == 0 || ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp_cyc = special ? 1 : 33;
      issue(op, a, b, rd, d, bc, bf, ov, r, ro);
      n_checks++;
      if (r !== ex || d !== exp_cyc || ro !== rd || ov !== 0) begin
        n_errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got result=%h cyc=%0d rd=%0d overlap=%0d, want %h/%0d/%0d/0",
                 i, op, a, b, r, d, ro, ov, ex, exp_cyc, rd);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; last_exp = 32'd0;
    rst = 1'b0;
    bus.i_start = 1'b0; bus.i_op = 3'b000; bus.i_rs1 = '0; bus.i_rs2 = '0;
    bus.i_rd_in = '0; bus.i_flush = 1'b0;
    test_reset();
    test_mul();
    test_back_to_back();
    test_special();
    test_flush();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_muldiv_unit
`default_nettype wire
